// File: rtl/data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_mem_responder: valid/ready RV32I data memory, fixed-latency response |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_funct3_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LAT_INIT  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [29:0] DEPTH_W30 = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic        w_accept;
    logic        w_is_byte, w_is_half, w_is_word, w_legal, w_oor, w_err;
    logic [AW-1:0] w_idx;
    logic [31:0] w_rword;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_rsp_rdata;
    logic [3:0]  w_be;
    logic [31:0] w_wword;
    logic        w_mem_we;

    assign w_accept    = req_valid_i && (state_q == S_IDLE);
    assign req_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                we_q    <= req_we_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                f3_q    <= req_funct3_i;
            end
            if (state_q == S_ACCESS) begin
                rdata_q <= w_rsp_rdata;
                err_q   <= w_err;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    if (LATENCY > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = LAT_INIT;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: state_d = S_RESP;
            default:  state_d = S_IDLE;
        endcase
    end

    // funct3 decode; LBU/LHU encodings are loads only
    always_comb begin
        w_is_byte = 1'b0;
        w_is_half = 1'b0;
        w_is_word = 1'b0;
        w_legal   = 1'b0;
        case (f3_q)
            3'b000: begin w_is_byte = 1'b1; w_legal = 1'b1;  end
            3'b001: begin w_is_half = 1'b1; w_legal = 1'b1;  end
            3'b010: begin w_is_word = 1'b1; w_legal = 1'b1;  end
            3'b100: begin w_is_byte = 1'b1; w_legal = !we_q; end
            3'b101: begin w_is_half = 1'b1; w_legal = !we_q; end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_oor = (addr_q[31:2] >= DEPTH_W30);
    assign w_err = !w_legal || (w_is_half && addr_q[0]) ||
                   (w_is_word && (addr_q[1:0] != 2'b00)) || w_oor;
    assign w_idx   = addr_q[AW+1:2];
    assign w_rword = mem_q[w_idx];

    always_comb begin
        w_byte = w_rword[7:0];
        case (addr_q[1:0])
            2'd0: w_byte = w_rword[7:0];
            2'd1: w_byte = w_rword[15:8];
            2'd2: w_byte = w_rword[23:16];
            default: w_byte = w_rword[31:24];
        endcase
        w_half = addr_q[1] ? w_rword[31:16] : w_rword[15:0];
        case (f3_q)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = w_rword;
        endcase
        w_rsp_rdata = (w_err || we_q) ? 32'd0 : w_load;
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wword = wdata_q;
        if (w_is_byte) begin
            w_be    = 4'b0001 << addr_q[1:0];
            w_wword = {4{wdata_q[7:0]}};
        end else if (w_is_half) begin
            w_be    = addr_q[1] ? 4'b1100 : 4'b0011;
            w_wword = {2{wdata_q[15:0]}};
        end
    end

    assign w_mem_we = (state_q == S_ACCESS) && we_q && !w_err;

    // Contents survive reset; a dropped request never reaches ACCESS
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    mem_q[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_data_mem_responder: randomized bench against a byte-level memory model |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT_A = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [2:0]  req_f3 = 3'd0;
    logic        valid_a = 1'b0;
    logic        valid_b = 1'b0;

    logic        ready_a, rsp_valid_a, err_a, busy_a;
    logic [31:0] rdata_a;
    logic        ready_b, rsp_valid_b, err_b, busy_b;
    logic [31:0] rdata_b;

    logic        cur_sel = 1'b0;
    logic        s_ready, s_valid, s_err, s_busy;
    logic [31:0] s_rdata;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mb [DEPTH*4];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) u_dut_a (
        .clk_i(clk), .reset_i(reset_n), .req_valid_i(valid_a), .req_ready_o(ready_a),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_funct3_i(req_f3), .rsp_valid_o(rsp_valid_a), .rsp_rdata_o(rdata_a),
        .rsp_err_o(err_a), .busy_o(busy_a)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut_b (
        .clk_i(clk), .reset_i(reset_n), .req_valid_i(valid_b), .req_ready_o(ready_b),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_funct3_i(req_f3), .rsp_valid_o(rsp_valid_b), .rsp_rdata_o(rdata_b),
        .rsp_err_o(err_b), .busy_o(busy_b)
    );

    assign s_ready = cur_sel ? ready_b     : ready_a;
    assign s_valid = cur_sel ? rsp_valid_b : rsp_valid_a;
    assign s_err   = cur_sel ? err_b       : err_a;
    assign s_busy  = cur_sel ? busy_b      : busy_a;
    assign s_rdata = cur_sel ? rdata_b     : rdata_a;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte-addressed reference: size from funct3[1:0], signedness from funct3[2]
    task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f, output logic e, output logic [31:0] r);
        int     size;
        bit     legal;
        longint v;
        size  = 1 << f[1:0];
        legal = (f[1:0] != 2'd3) && !(f[2] && (w || f[1:0] == 2'd2));
        e     = !legal || ((a % size) != 0) || ((a / 4) >= DEPTH);
        r     = 32'd0;
        if (!e) begin
            if (w) begin
                for (int i = 0; i < size; i++) mb[a + i] = d[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < size; i++) v = v | (longint'(mb[a + i]) << (8 * i));
                if (!f[2] && size < 4 && v[8*size-1]) v = v - (longint'(1) << (8 * size));
                r = v[31:0];
            end
        end
    endtask

    // Starts and ends on a falling edge with the selected responder idle
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f, output logic [31:0] rd, output logic e);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat;
        lat = cur_sel ? 0 : LAT_A;
        model(w, a, d, f, exp_err, exp_rd);
        chk_eq("ready_before_req", s_ready, 1);
        req_we = w; req_addr = a; req_wdata = d; req_f3 = f;
        if (cur_sel) valid_b = 1'b1; else valid_a = 1'b1;
        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge clk);
            if (k == 1) begin valid_a = 1'b0; valid_b = 1'b0; end
            chk_eq("ready_in_flight", s_ready, 0);
            chk_eq("busy_in_flight", s_busy, 1);
            chk_eq("rsp_valid_timing", s_valid, (k == lat + 2));
        end
        rd = s_rdata;
        e  = s_err;
        chk_eq("rsp_err", s_err, exp_err);
        chk_eq("rsp_rdata", s_rdata, exp_rd);
        @(negedge clk);
        chk_eq("ready_after_rsp", s_ready, 1);
        chk_eq("busy_after_rsp", s_busy, 0);
        chk_eq("rsp_valid_single", s_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, saved;
        logic        e, exp_e;
        logic [31:0] lw_addr [3];
        logic [31:0] lw_exp  [3];
        int          r;
        logic [31:0] a;

        repeat (3) @(negedge clk);
        chk_eq("reset_ready_a", ready_a, 1);
        chk_eq("reset_rsp_valid_a", rsp_valid_a, 0);
        chk_eq("reset_rdata_a", rdata_a, 0);
        chk_eq("reset_err_a", err_a, 0);
        chk_eq("reset_busy_a", busy_a, 0);
        chk_eq("reset_ready_b", ready_b, 1);
        chk_eq("reset_busy_b", busy_b, 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int w = 0; w < 32; w++) begin
            a = 32'(w * 4);
            req_wdata = $urandom;
            saved = req_wdata;
            cur_sel = 1'b0; txn(1'b1, a, saved, 3'b010, rd, e);
            cur_sel = 1'b1; txn(1'b1, a, saved, 3'b010, rd, e);
        end

        // LATENCY=0: valid held high across three back-to-back loads
        cur_sel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lw_addr[i] = 32'(i * 4);
            model(1'b0, lw_addr[i], 32'd0, 3'b010, exp_e, lw_exp[i]);
        end
        req_we = 1'b0; req_f3 = 3'b010; req_addr = lw_addr[0]; valid_b = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            if (c == 1) req_addr = lw_addr[1];
            if (c == 4) req_addr = lw_addr[2];
            if (c == 7) valid_b = 1'b0;
            chk_eq("lat0_ready", ready_b, (c % 3 == 0));
            chk_eq("lat0_busy", busy_b, (c % 3 != 0));
            chk_eq("lat0_rsp_valid", rsp_valid_b, (c == 2 || c == 5 || c == 8));
            if (c == 2 || c == 5 || c == 8) chk_eq("lat0_rdata", rdata_b, lw_exp[c / 3]);
            @(negedge clk);
        end

        cur_sel = 1'b0;
        txn(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, e);
        chk_eq("sw_rdata_zero", rd, 32'd0);
        txn(1'b0, 32'h10, 32'd0, 3'b010, rd, e);
        chk_eq("lw_deadbeef", rd, 32'hDEADBEEF);
        txn(1'b1, 32'h10, 32'h11223344, 3'b010, rd, e);
        txn(1'b1, 32'h13, 32'h000000F0, 3'b000, rd, e);
        txn(1'b0, 32'h10, 32'd0, 3'b010, rd, e);
        chk_eq("sb_merge", rd, 32'hF0223344);
        txn(1'b0, 32'h13, 32'd0, 3'b000, rd, e);
        chk_eq("lb_sign", rd, 32'hFFFFFFF0);
        txn(1'b0, 32'h13, 32'd0, 3'b100, rd, e);
        chk_eq("lbu_zero", rd, 32'h000000F0);
        txn(1'b1, 32'h16, 32'h00008001, 3'b001, rd, e);
        txn(1'b0, 32'h16, 32'd0, 3'b001, rd, e);
        chk_eq("lh_sign", rd, 32'hFFFF8001);
        txn(1'b0, 32'h16, 32'd0, 3'b101, rd, e);
        chk_eq("lhu_zero", rd, 32'h00008001);
        txn(1'b0, 32'h12, 32'd0, 3'b010, rd, e);
        chk_eq("lw_misalign_err", e, 1);
        txn(1'b0, 32'h20, 32'd0, 3'b010, saved, e);
        txn(1'b1, 32'h21, 32'h0000ABCD, 3'b001, rd, e);
        chk_eq("sh_misalign_err", e, 1);
        txn(1'b0, 32'h20, 32'd0, 3'b010, rd, e);
        chk_eq("sh_err_no_write", rd, saved);
        txn(1'b0, 32'(DEPTH * 4), 32'd0, 3'b010, rd, e);
        chk_eq("lw_range_err", e, 1);
        txn(1'b0, 32'h0, 32'd0, 3'b011, rd, e);
        chk_eq("funct3_011_err", e, 1);

        // Reset during WAIT drops the store
        req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h12345678; req_f3 = 3'b010;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        chk_eq("rst_test_busy", busy_a, 1);
        #2 reset_n = 1'b0;
        #1;
        chk_eq("rst_ready_async", ready_a, 1);
        chk_eq("rst_busy_async", busy_a, 0);
        chk_eq("rst_rsp_valid", rsp_valid_a, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk_eq("rst_no_rsp", rsp_valid_a, 0);
        end
        txn(1'b0, 32'h40, 32'd0, 3'b010, rd, e);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = 32'(DEPTH * 4) + $urandom_range(0, 63);
            else if (r == 1) a = $urandom | 32'h8000_0000;
            else             a = $urandom_range(0, 127);
            txn(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)), rd, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
